tcycle_scheduler: RTL and testbench
===================================

# tcycle_scheduler

Parametrised time-slot scheduler generating the per-unit T-cycle enables for the emulator core. One scheduling period spans NUM_CH equal slots plus an optional settle window. Each enabled channel (CPU, PPU, MEM, …) receives a one-cycle tick at the start of its slot. The block adds run/pause/single-step control, per-channel tick gating and an M-cycle tick, and replaces the hard-wired 25-cycle duty-cycle logic in the top level.

## Interface
- NUM_CH, 3: number of channel slots per period (≥1)
- SLOT_LEN, 8: cycles per channel slot (≥1)
- SETTLE_LEN, 1: settle cycles after the last slot (≥0)
- MCYCLE_DIV, 4: periods per M-cycle (≥1)
- Derived: PERIOD = NUM_CH*SLOT_LEN + SETTLE_LEN; PW = max(1,$clog2(PERIOD)); SW = max(1,$clog2(NUM_CH+1))

- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- run_in  in  1  1 = free-run; 0 = pause at next period boundary
- step_in  in  1  while paused, request exactly one period
- ch_en_in  in  NUM_CH  per-channel tick enable, latched at period start
- phase_out  out  PW  position within period
- slot_out  out  SW  current slot index; NUM_CH during settle
- active_out  out  NUM_CH  one-hot slot ownership; 0 during settle or pause
- tick_out  out  NUM_CH  one-cycle pulse on first cycle of slot i if en_q[i]
- settle_out  out  1  high during settle cycles
- tcycle_tick_out  out  1  pulse on last cycle of every executed period
- mcycle_tick_out  out  1  pulse on last cycle of every MCYCLE_DIV-th executed period
- paused_out  out  1  high in PAUSED

## Operation
- State (registered): PAUSED, RUN, STEP. Phase counter `phase`, period counter `mcnt` (0..MCYCLE_DIV-1), latched mask `en_q`.
- Reset (rst_in=0 at clock edge):
  - state=PAUSED, phase=0, mcnt=0, en_q=0.
  - Outputs: paused_out=1, all others 0.
- PAUSED:
  - phase held at 0.
  - run_in=1 → RUN. Else step_in=1 → STEP. run_in wins if both are high.
  - On either transition, en_q ← ch_en_in.
- RUN/STEP:
  - phase increments each cycle, wrapping PERIOD-1→0.
  - At phase==PERIOD-1 (end of period): mcnt advances mod MCYCLE_DIV.
  - RUN at end of period: if run_in=1, stay RUN and en_q ← ch_en_in; else → PAUSED.
  - STEP at end of period: if run_in=1 → RUN and reload en_q; else → PAUSED.
  - step_in is ignored outside PAUSED.
- Decode (combinational from registered state only; no input→output path). "running" means RUN or STEP.
  - slot = phase / SLOT_LEN when phase < NUM_CH*SLOT_LEN, else NUM_CH.
  - active_out[i] = running && slot==i.
  - tick_out[i] = running && phase==i*SLOT_LEN && en_q[i].
  - settle_out = running && slot==NUM_CH.
  - tcycle_tick_out = running && phase==PERIOD-1.
  - mcycle_tick_out = tcycle_tick_out && mcnt==MCYCLE_DIV-1.
  - slot_out = running ? slot : 0.
- Arithmetic: phase compares use PW-bit unsigned. Slot division is implemented as a sub-counter (0..SLOT_LEN-1) plus slot index, not a divider.
- SETTLE_LEN=0: no settle slot. The last cycle of slot NUM_CH-1 is the period end.
- Pausing preserves mcnt. Resumed periods continue the M-cycle count.
- Illegal parameters (NUM_CH, SLOT_LEN or MCYCLE_DIV < 1) fail an elaboration-time assertion.

## Timing
- The cycle run_in=1 is sampled in PAUSED is followed by RUN with phase=0. tick_out[0] is asserted in that same following cycle if enabled: 1-cycle latency.
- ch_en_in changes take effect only from the next period start. The mask is never re-sampled mid-period.
- Dropping run_in mid-period: the period completes. PAUSED holds from the cycle after phase==PERIOD-1.
- A step pulse yields exactly PERIOD running cycles, exactly one tcycle_tick_out, then PAUSED, unless run_in is raised.
- Reset mid-period: the next cycle shows reset values. No partial tick completes.

## Structure
- Shared package `gb_sched_pkg`:
  - sched_state_t enum {PAUSED, RUN, STEP}
  - channel index constants CH_CPU=0, CH_PPU=1, CH_MEM=2
  - default SLOT_LEN/SETTLE_LEN constants used by the top level
- One sub-module: the existing EvtCounter, instantiated with MAX_COUNT=MCYCLE_DIV for mcnt. It is fed evt_in=tcycle_tick_out and rst_in=~rst_in.

## Test plan
- Reset, then run_in=1, ch_en_in=3'b111, defaults → ticks at phase 0/8/16, settle_out at 24, tcycle_tick_out every 25 cycles.
- Free-run 100 cycles → exactly one mcycle_tick_out, coincident with the 4th tcycle_tick_out (phase 24).
- ch_en_in 3'b101→3'b111 at phase 5 → no tick_out[1] at phase 8 of that period; tick_out[1] present at phase 8 of the next.
- run_in dropped at phase 10 → phase runs to 24, then paused_out=1, active_out=0, phase_out=0 held. step_in/run_in high together → RUN.
- step_in pulse while paused → 25 running cycles, 3 ticks, 1 tcycle_tick_out, back to PAUSED. step_in during RUN → no effect.
- rst_in=0 at phase 13 after 2 periods → next cycle all outputs 0, paused_out=1. After restart, mcycle_tick_out first appears after 4 further periods.

Source files
------------

// File: rtl/gb_sched_pkg.sv
// rtl/gb_sched_pkg.sv - shared scheduler types, channel indices and default timing
package gb_sched_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } sched_state_t;

  localparam int CH_CPU = 0;
  localparam int CH_PPU = 1;
  localparam int CH_MEM = 2;

  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_SLOT_LEN   = 8;
  localparam int DEF_SETTLE_LEN = 1;
  localparam int DEF_MCYCLE_DIV = 4;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/tcycle_scheduler_evt_counter.sv
// rtl/tcycle_scheduler_evt_counter.sv - modulo-MAX_COUNT event counter
module EvtCounter #(
  parameter int MAX_COUNT = 4,
  localparam int CW = (MAX_COUNT <= 2) ? 1 : $clog2(MAX_COUNT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          evt_in,
  output logic [CW-1:0] count_out
);

  // Active-high synchronous reset; reset dominates a coincident event.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_out <= '0;
    end else if (evt_in) begin
      if (count_out == CW'(MAX_COUNT - 1)) count_out <= '0;
      else                                 count_out <= count_out + CW'(1);
    end
  end

endmodule

// File: rtl/tcycle_scheduler.sv
// rtl/tcycle_scheduler.sv - slot scheduler producing per-channel T-cycle ticks and M-cycle tick
module tcycle_scheduler
  import gb_sched_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int SLOT_LEN   = DEF_SLOT_LEN,
  parameter int SETTLE_LEN = DEF_SETTLE_LEN,
  parameter int MCYCLE_DIV = DEF_MCYCLE_DIV,
  localparam int PERIOD    = NUM_CH * SLOT_LEN + SETTLE_LEN,
  localparam int PW        = clog2_min1(PERIOD),
  localparam int SW        = clog2_min1(NUM_CH + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              run_in,
  input  logic              step_in,
  input  logic [NUM_CH-1:0] ch_en_in,
  output logic [PW-1:0]     phase_out,
  output logic [SW-1:0]     slot_out,
  output logic [NUM_CH-1:0] active_out,
  output logic [NUM_CH-1:0] tick_out,
  output logic              settle_out,
  output logic              tcycle_tick_out,
  output logic              mcycle_tick_out,
  output logic              paused_out
);

  localparam int SUBW = clog2_min1(SLOT_LEN);
  localparam int MW   = clog2_min1(MCYCLE_DIV);

  if (NUM_CH < 1 || SLOT_LEN < 1 || MCYCLE_DIV < 1 || SETTLE_LEN < 0) begin : g_param_check
    $error("tcycle_scheduler: NUM_CH, SLOT_LEN and MCYCLE_DIV must be >= 1, SETTLE_LEN >= 0");
  end

  sched_state_t      state;
  logic [PW-1:0]     phase;
  logic [SUBW-1:0]   sub;
  logic [SW-1:0]     slot;
  logic [NUM_CH-1:0] en_q;
  logic [MW-1:0]     mcnt;
  logic              running;
  logic              in_settle;
  logic              period_end;

  assign running    = (state != PAUSED);
  assign in_settle  = (slot == SW'(NUM_CH));
  assign period_end = running && (phase == PW'(PERIOD - 1));

  // slot/sub track phase/SLOT_LEN and phase%SLOT_LEN incrementally; both park during settle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= PAUSED;
      phase <= '0;
      sub   <= '0;
      slot  <= '0;
      en_q  <= '0;
    end else begin
      case (state)
        PAUSED: begin
          phase <= '0;
          sub   <= '0;
          slot  <= '0;
          if (run_in) begin
            state <= RUN;
            en_q  <= ch_en_in;
          end else if (step_in) begin
            state <= STEP;
            en_q  <= ch_en_in;
          end
        end
        RUN, STEP: begin
          if (period_end) begin
            phase <= '0;
            sub   <= '0;
            slot  <= '0;
            if (run_in) begin
              state <= RUN;
              en_q  <= ch_en_in;
            end else begin
              state <= PAUSED;
            end
          end else begin
            phase <= phase + PW'(1);
            if (!in_settle) begin
              if (sub == SUBW'(SLOT_LEN - 1)) begin
                sub  <= '0;
                slot <= slot + SW'(1);
              end else begin
                sub <= sub + SUBW'(1);
              end
            end
          end
        end
        default: state <= PAUSED;
      endcase
    end
  end

  EvtCounter #(
    .MAX_COUNT(MCYCLE_DIV)
  ) u_mcycle_cnt (
    .clk_in   (clk_in),
    .rst_in   (~rst_in),
    .evt_in   (tcycle_tick_out),
    .count_out(mcnt)
  );

  always_comb begin
    phase_out       = phase;
    slot_out        = running ? slot : '0;
    active_out      = '0;
    tick_out        = '0;
    settle_out      = running && in_settle;
    tcycle_tick_out = period_end;
    mcycle_tick_out = period_end && (mcnt == MW'(MCYCLE_DIV - 1));
    paused_out      = !running;
    for (int i = 0; i < NUM_CH; i++) begin
      active_out[i] = running && (slot == SW'(i));
      tick_out[i]   = running && (slot == SW'(i)) && (sub == '0) && en_q[i];
    end
  end

endmodule

// File: tb/tb_tcycle_scheduler.sv
// tb/tb_tcycle_scheduler.sv - self-checking bench for tcycle_scheduler with a period-level reference model
module tb_tcycle_scheduler;

  localparam int NCH = 3;
  localparam int SL  = 8;
  localparam int ST  = 1;
  localparam int MD  = 4;
  localparam int PER = NCH * SL + ST;

  logic       clk = 1'b0;
  logic       rstn, run, step;
  logic [2:0] en;
  logic [4:0] phase_out;
  logic [1:0] slot_out;
  logic [2:0] active_out, tick_out;
  logic       settle_out, tt_out, mt_out, paused_out;

  int tests = 0;
  int fails = 0;

  bit         m_running;
  int         m_phase;
  int         m_periods;
  logic [2:0] m_en;

  always #5 clk = ~clk;

  tcycle_scheduler #(
    .NUM_CH(NCH), .SLOT_LEN(SL), .SETTLE_LEN(ST), .MCYCLE_DIV(MD)
  ) dut (
    .clk_in(clk), .rst_in(rstn), .run_in(run), .step_in(step), .ch_en_in(en),
    .phase_out(phase_out), .slot_out(slot_out), .active_out(active_out),
    .tick_out(tick_out), .settle_out(settle_out), .tcycle_tick_out(tt_out),
    .mcycle_tick_out(mt_out), .paused_out(paused_out)
  );

  function automatic logic [16:0] exp_vec();
    int slot;
    logic [2:0] act, tk;
    logic stl, tt, mt;
    slot = (m_phase < NCH * SL) ? m_phase / SL : NCH;
    act  = (m_running && slot < NCH) ? 3'(1 << slot) : 3'b000;
    tk   = (m_running && slot < NCH && (m_phase % SL) == 0) ? (act & m_en) : 3'b000;
    stl  = m_running && slot == NCH;
    tt   = m_running && m_phase == PER - 1;
    mt   = tt && ((m_periods % MD) == MD - 1);
    return {5'(m_phase), m_running ? 2'(slot) : 2'd0, act, tk, stl, tt, mt, !m_running};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {phase_out, slot_out, active_out, tick_out, settle_out, tt_out, mt_out, paused_out};
  endfunction

  task automatic model_update();
    if (!rstn) begin
      m_running = 0; m_phase = 0; m_periods = 0; m_en = 3'b000;
    end else if (!m_running) begin
      if (run || step) begin
        m_running = 1; m_en = en;
      end
    end else if (m_phase == PER - 1) begin
      m_phase = 0;
      m_periods++;
      if (run) m_en = en;
      else     m_running = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; run = 1'b0; step = 1'b0; en = 3'b000;
    clk_step();
    clk_step();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_vec: got %h expected %h", obs_vec(), exp_vec());
    end
    tests++;
    if (obs_vec() !== 17'h00001) begin
      fails++; $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 17'h00001);
    end
    rstn = 1'b1;
    clk_step();
  endtask

  task automatic test_free_run();
    int ntt = 0, nmt = 0, mt_at = -1;
    run = 1'b1; en = 3'b111;
    clk_step();
    tests++;
    if (tick_out !== 3'b001 || phase_out !== 5'd0) begin
      fails++; $display("FAIL start_latency: tick %b phase %0d expected tick 001 phase 0", tick_out, phase_out);
    end
    for (int i = 0; i < 100; i++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL free_run cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (tt_out) ntt++;
      if (mt_out) begin nmt++; mt_at = ntt; end
      clk_step();
    end
    tests++;
    if (ntt !== 4 || nmt !== 1 || mt_at !== 4) begin
      fails++; $display("FAIL free_run_counts: tcycle %0d mcycle %0d at %0d expected 4 1 4", ntt, nmt, mt_at);
    end
  endtask

  task automatic test_mask_change();
    en = 3'b101;
    repeat (PER + 5) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL mask_pre: got %h expected %h", obs_vec(), exp_vec());
      end
      clk_step();
    end
    en = 3'b111;
    repeat (3) clk_step();
    tests++;
    if (tick_out !== 3'b000 || phase_out !== 5'd8) begin
      fails++; $display("FAIL mask_midperiod: tick %b phase %0d expected 000 at phase 8", tick_out, phase_out);
    end
    repeat (PER) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL mask_post: got %h expected %h", obs_vec(), exp_vec());
      end
      clk_step();
    end
    tests++;
    if (tick_out !== 3'b010 || phase_out !== 5'd8) begin
      fails++; $display("FAIL mask_next_period: tick %b phase %0d expected 010 at phase 8", tick_out, phase_out);
    end
  endtask

  task automatic test_pause();
    repeat (2) clk_step();
    run = 1'b0;
    repeat (PER - 1 - 10) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL pause_drain: got %h expected %h", obs_vec(), exp_vec());
      end
      clk_step();
    end
    tests++;
    if (tt_out !== 1'b1 || phase_out !== 5'd24 || paused_out !== 1'b0) begin
      fails++; $display("FAIL pause_last: tt %b phase %0d paused %b expected 1 24 0", tt_out, phase_out, paused_out);
    end
    step = 1'b0;
    repeat (3) begin
      clk_step();
      tests++;
      if (paused_out !== 1'b1 || active_out !== 3'b000 || phase_out !== 5'd0 || tick_out !== 3'b000) begin
        fails++; $display("FAIL pause_hold: paused %b active %b phase %0d tick %b expected 1 000 0 000",
                          paused_out, active_out, phase_out, tick_out);
      end
    end
    run = 1'b1; step = 1'b1;
    clk_step();
    step = 1'b0;
    tests++;
    if (paused_out !== 1'b0 || phase_out !== 5'd0) begin
      fails++; $display("FAIL run_and_step: paused %b phase %0d expected 0 0", paused_out, phase_out);
    end
    repeat (PER + 3) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL resume: got %h expected %h", obs_vec(), exp_vec());
      end
      clk_step();
    end
  endtask

  task automatic test_step();
    int nrun = 0, nticks = 0, ntt = 0;
    step = 1'b1;
    repeat (6) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL step_in_run: got %h expected %h", obs_vec(), exp_vec());
      end
      clk_step();
    end
    step = 1'b0; run = 1'b0;
    for (int i = 0; i < 40 && m_running; i++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL step_drain: got %h expected %h", obs_vec(), exp_vec());
      end
      clk_step();
    end
    tests++;
    if (paused_out !== 1'b1) begin
      fails++; $display("FAIL step_prepause: paused %b expected 1", paused_out);
    end
    en = 3'b111; step = 1'b1;
    clk_step();
    step = 1'b0;
    for (int i = 0; i < 40 && paused_out !== 1'b1; i++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL step_period: got %h expected %h", obs_vec(), exp_vec());
      end
      nrun++;
      nticks += $countones(tick_out);
      if (tt_out) ntt++;
      clk_step();
    end
    tests++;
    if (nrun !== PER || nticks !== 3 || ntt !== 1) begin
      fails++; $display("FAIL step_counts: cycles %0d ticks %0d tcycle %0d expected %0d 3 1", nrun, nticks, ntt, PER);
    end
  endtask

  task automatic test_reset_mid();
    int ntt = 0, mt_at = -1;
    run = 1'b1;
    clk_step();
    repeat (2 * PER + 13) clk_step();
    rstn = 1'b0;
    clk_step();
    tests++;
    if (obs_vec() !== 17'h00001) begin
      fails++; $display("FAIL reset_mid: got %h expected %h", obs_vec(), 17'h00001);
    end
    rstn = 1'b1;
    clk_step();
    for (int i = 0; i < 200; i++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL reset_restart: got %h expected %h", obs_vec(), exp_vec());
      end
      if (tt_out) ntt++;
      if (mt_out) begin mt_at = ntt; break; end
      clk_step();
    end
    tests++;
    if (mt_at !== 4) begin
      fails++; $display("FAIL reset_mcycle: first mcycle at tcycle %0d expected 4", mt_at);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) run = ~run;
      step = ($urandom_range(0, 19) == 0);
      en   = 3'($urandom_range(0, 7));
      rstn = ($urandom_range(0, 299) != 0);
      clk_step();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    rstn = 1'b1; step = 1'b0;
  endtask

  initial begin
    m_running = 0; m_phase = 0; m_periods = 0; m_en = 3'b000;
    rstn = 1'b0; run = 1'b0; step = 1'b0; en = 3'b000;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_mask_change();
    test_pause();
    test_step();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
